axis_line_flip_pp: RTL and testbench

// - Parametrised successor to the single-buffer line flipper: AXI4-Stream video line mirror with ping-pong line banks.
// - Accepts line N+1 while line N is emitted; runtime line length; runtime flip/pass mode; per-line SOF (tuser) forwarding.
// - Sits between the video DMA/MM2S stream and downstream pixel pipeline, single clock domain.

---
 rtl/image_flip_pkg.sv | 24 ++
 rtl/line_bank_ram.sv | 30 +++
 rtl/axis_line_flip_pp.sv | 255 +++++++++++++++++++++++++
 tb/tb_axis_line_flip_pp.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_flip_pkg.sv
// Shared types and defaults for the ping-pong AXI4-Stream line flipper.
package image_flip_pkg;

    localparam int unsigned DEF_TDATA_WIDTH    = 32;
    localparam int unsigned DEF_MAX_LINE_WIDTH = 1024;

    // Read-side sequencing: idle, first RAM read in flight, streaming a bank.
    typedef enum logic [1:0] {
        R_IDLE     = 2'd0,
        R_PREFETCH = 2'd1,
        R_STREAM   = 2'd2
    } rd_state_e;

    // Per-line pixel ordering.
    localparam logic MODE_PASS = 1'b0;
    localparam logic MODE_FLIP = 1'b1;

    // Sideband travelling with each output beat.
    typedef struct packed {
        logic last;
        logic user;
    } beat_tag_t;

endpackage

// File: rtl/line_bank_ram.sv
// Simple dual-port line store: one write port, one registered read port.
// The address MSB selects the bank, so both line banks share one BRAM.
module line_bank_ram
    import image_flip_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_TDATA_WIDTH,
    parameter int unsigned ADDR_W = 11
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    // Write port and enabled, registered read port (no reset: maps to BRAM).
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/axis_line_flip_pp.sv
// AXI4-Stream video line mirror with two line banks: one line is written
// while the previous one is read back, either reversed or in order.
module axis_line_flip_pp
    import image_flip_pkg::*;
#(
    parameter int unsigned C_AXIS_TDATA_WIDTH = DEF_TDATA_WIDTH,
    parameter int unsigned C_MAX_LINE_WIDTH   = DEF_MAX_LINE_WIDTH,
    parameter int unsigned C_PTR_W            = $clog2(C_MAX_LINE_WIDTH + 1)
) (
    input  logic                              s00_axis_aclk,
    input  logic                              s00_axis_aresetn,
    input  logic [C_PTR_W-1:0]                cfg_line_width,
    input  logic                              cfg_hflip,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic                              s00_axis_tuser,
    input  logic                              s00_axis_tlast,
    input  logic                              s00_axis_tvalid,
    output logic                              s00_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic                              m00_axis_tuser,
    output logic                              m00_axis_tlast,
    output logic                              m00_axis_tvalid,
    input  logic                              m00_axis_tready,
    output logic                              err_short_line,
    output logic                              err_long_line
);

    localparam int unsigned OFF_W  = (C_MAX_LINE_WIDTH > 1) ? $clog2(C_MAX_LINE_WIDTH) : 1;
    localparam int unsigned ADDR_W = OFF_W + 1;
    localparam logic [C_PTR_W-1:0] MAX_LEN = C_PTR_W'(C_MAX_LINE_WIDTH);

    // Write-side state
    logic                   tready_q;
    logic                   wr_bank_q;
    logic [C_PTR_W-1:0]     wr_ptr_q;
    logic [C_PTR_W-1:0]     width_q;
    logic                   flip_q;
    logic                   sof_q;
    logic                   err_short_q;
    logic                   err_long_q;

    // Per-bank line descriptors
    logic [1:0]             full_q;
    logic [C_PTR_W-1:0]     len_q [2];
    logic [1:0]             bflip_q;
    logic [1:0]             bsof_q;

    // Read-side state
    rd_state_e              rd_state_q;
    logic                   rd_bank_q;
    logic [C_PTR_W-1:0]     rd_k_q;
    logic                   inflight_q;
    beat_tag_t              inflight_tag_q;
    logic                   head_vld_q;
    logic [C_AXIS_TDATA_WIDTH-1:0] head_data_q;
    beat_tag_t              head_tag_q;
    logic                   tail_vld_q;
    logic [C_AXIS_TDATA_WIDTH-1:0] tail_data_q;
    beat_tag_t              tail_tag_q;

    // Combinational
    logic [C_PTR_W-1:0]     cfg_w_c;
    logic                   first_c;
    logic [C_PTR_W-1:0]     eff_w_c;
    logic                   eff_flip_c;
    logic                   eff_sof_c;
    logic                   acc_c;
    logic [C_PTR_W-1:0]     ptr_inc_c;
    logic                   at_w_c;
    logic                   close_c;
    logic                   short_c;
    logic                   long_c;
    logic [ADDR_W-1:0]      wr_addr_c;
    logic [C_PTR_W-1:0]     rd_len_c;
    logic                   pop_c;
    logic                   free_c;
    logic [1:0]             occ_c;
    logic                   issue_c;
    logic [ADDR_W-1:0]      rd_addr_c;
    logic [1:0]             full_d;
    logic                   wr_bank_d;
    logic [C_AXIS_TDATA_WIDTH-1:0] ram_rdata;

    // Write-side decode: line width/mode/SOF come from cfg on the first beat of a line.
    always_comb begin
        cfg_w_c = cfg_line_width;
        if ((cfg_line_width == '0) || (cfg_line_width > MAX_LEN)) begin
            cfg_w_c = MAX_LEN;
        end
        first_c    = (wr_ptr_q == '0);
        eff_w_c    = first_c ? cfg_w_c : width_q;
        eff_flip_c = first_c ? cfg_hflip : flip_q;
        eff_sof_c  = first_c ? s00_axis_tuser : sof_q;
        acc_c      = s00_axis_tvalid & tready_q;
        ptr_inc_c  = wr_ptr_q + C_PTR_W'(1);
        at_w_c     = (ptr_inc_c == eff_w_c);
        close_c    = acc_c & (s00_axis_tlast | at_w_c);
        short_c    = acc_c & s00_axis_tlast & ~at_w_c;
        long_c     = acc_c & ~s00_axis_tlast & at_w_c;
        wr_addr_c  = {wr_bank_q, OFF_W'(wr_ptr_q)};
    end

    // Read-side decode: issue a RAM read only when the skid stage has room for it.
    always_comb begin
        rd_len_c  = len_q[rd_bank_q];
        pop_c     = head_vld_q & m00_axis_tready;
        free_c    = pop_c & head_tag_q.last;
        occ_c     = 2'(head_vld_q) + 2'(tail_vld_q) + 2'(inflight_q);
        issue_c   = full_q[rd_bank_q] & (rd_k_q < rd_len_c) & (occ_c <= (2'd1 + 2'(pop_c)));
        rd_addr_c = {rd_bank_q, OFF_W'((bflip_q[rd_bank_q] == MODE_FLIP)
                                       ? (rd_len_c - C_PTR_W'(1) - rd_k_q) : rd_k_q)};
    end

    // Bank occupancy: close and free always target different banks.
    always_comb begin
        full_d = full_q;
        if (close_c) begin
            full_d[wr_bank_q] = 1'b1;
        end
        if (free_c) begin
            full_d[rd_bank_q] = 1'b0;
        end
        wr_bank_d = wr_bank_q ^ close_c;
    end

    // Write control, bank descriptors, error pulses and registered tready.
    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            tready_q    <= 1'b0;
            wr_bank_q   <= 1'b0;
            wr_ptr_q    <= '0;
            width_q     <= MAX_LEN;
            flip_q      <= MODE_PASS;
            sof_q       <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            full_q      <= '0;
            len_q[0]    <= '0;
            len_q[1]    <= '0;
            bflip_q     <= '0;
            bsof_q      <= '0;
        end else begin
            tready_q    <= ~full_d[wr_bank_d];
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            err_short_q <= short_c;
            err_long_q  <= long_c;
            if (acc_c) begin
                if (first_c) begin
                    width_q <= cfg_w_c;
                    flip_q  <= cfg_hflip;
                    sof_q   <= s00_axis_tuser;
                end
                wr_ptr_q <= close_c ? '0 : ptr_inc_c;
            end
            if (close_c) begin
                len_q[wr_bank_q]   <= ptr_inc_c;
                bflip_q[wr_bank_q] <= eff_flip_c;
                bsof_q[wr_bank_q]  <= eff_sof_c;
            end
        end
    end

    // Read FSM, RAM read tagging and the 2-entry output skid stage.
    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            rd_state_q     <= R_IDLE;
            rd_bank_q      <= 1'b0;
            rd_k_q         <= '0;
            inflight_q     <= 1'b0;
            inflight_tag_q <= '0;
            head_vld_q     <= 1'b0;
            head_data_q    <= '0;
            head_tag_q     <= '0;
            tail_vld_q     <= 1'b0;
            tail_data_q    <= '0;
            tail_tag_q     <= '0;
        end else begin
            inflight_q <= issue_c;
            if (issue_c) begin
                inflight_tag_q.last <= (rd_k_q == (rd_len_c - C_PTR_W'(1)));
                inflight_tag_q.user <= (rd_k_q == '0) & bsof_q[rd_bank_q];
                rd_k_q              <= rd_k_q + C_PTR_W'(1);
            end

            case (rd_state_q)
                R_IDLE: begin
                    if (full_q[rd_bank_q]) begin
                        rd_state_q <= R_PREFETCH;
                    end
                end
                R_PREFETCH: begin
                    rd_state_q <= R_STREAM;
                end
                R_STREAM: begin
                    if (free_c) begin
                        rd_state_q <= R_IDLE;
                        rd_bank_q  <= ~rd_bank_q;
                        rd_k_q     <= '0;
                    end
                end
                default: begin
                    rd_state_q <= R_IDLE;
                end
            endcase

            if (!head_vld_q || pop_c) begin
                if (tail_vld_q) begin
                    head_vld_q  <= 1'b1;
                    head_data_q <= tail_data_q;
                    head_tag_q  <= tail_tag_q;
                    tail_vld_q  <= inflight_q;
                    if (inflight_q) begin
                        tail_data_q <= ram_rdata;
                        tail_tag_q  <= inflight_tag_q;
                    end
                end else begin
                    head_vld_q <= inflight_q;
                    if (inflight_q) begin
                        head_data_q <= ram_rdata;
                        head_tag_q  <= inflight_tag_q;
                    end
                end
            end else if (inflight_q) begin
                tail_vld_q  <= 1'b1;
                tail_data_q <= ram_rdata;
                tail_tag_q  <= inflight_tag_q;
            end
        end
    end

    line_bank_ram #(
        .DATA_W (C_AXIS_TDATA_WIDTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (s00_axis_aclk),
        .we_i    (acc_c),
        .waddr_i (wr_addr_c),
        .wdata_i (s00_axis_tdata),
        .re_i    (issue_c),
        .raddr_i (rd_addr_c),
        .rdata_o (ram_rdata)
    );

    assign s00_axis_tready = tready_q;
    assign m00_axis_tvalid = head_vld_q;
    assign m00_axis_tdata  = head_data_q;
    assign m00_axis_tlast  = head_tag_q.last;
    assign m00_axis_tuser  = head_tag_q.user;
    assign m00_axis_tstrb  = '1;
    assign err_short_line  = err_short_q;
    assign err_long_line   = err_long_q;

endmodule

// File: tb/tb_axis_line_flip_pp.sv
// Scoreboard bench for axis_line_flip_pp: a line-level reference model queues
// expected output beats; an independent monitor checks every output handshake.
module tb_axis_line_flip_pp;

    localparam int unsigned DW   = 32;
    localparam int unsigned MAXW = 1024;
    localparam int unsigned PW   = $clog2(MAXW + 1);

    logic            clk = 1'b0;
    logic            rst_n;
    logic [PW-1:0]   cfg_line_width;
    logic            cfg_hflip;
    logic [DW-1:0]   s_tdata;
    logic            s_tuser;
    logic            s_tlast;
    logic            s_tvalid;
    logic            s_tready;
    logic [DW-1:0]   m_tdata;
    logic [DW/8-1:0] m_tstrb;
    logic            m_tuser;
    logic            m_tlast;
    logic            m_tvalid;
    logic            m_tready = 1'b0;
    logic            err_short;
    logic            err_long;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic          user;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] line_q[$];
    int unsigned   line_w;
    logic          line_flip;
    logic          line_sof;

    int n_checks  = 0;
    int n_fail    = 0;
    int pops      = 0;
    int in_stalls = 0;
    int rdy_mode  = 0;

    always #5 clk = ~clk;

    axis_line_flip_pp dut (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (rst_n),
        .cfg_line_width   (cfg_line_width),
        .cfg_hflip        (cfg_hflip),
        .s00_axis_tdata   (s_tdata),
        .s00_axis_tuser   (s_tuser),
        .s00_axis_tlast   (s_tlast),
        .s00_axis_tvalid  (s_tvalid),
        .s00_axis_tready  (s_tready),
        .m00_axis_tdata   (m_tdata),
        .m00_axis_tstrb   (m_tstrb),
        .m00_axis_tuser   (m_tuser),
        .m00_axis_tlast   (m_tlast),
        .m00_axis_tvalid  (m_tvalid),
        .m00_axis_tready  (m_tready),
        .err_short_line   (err_short),
        .err_long_line    (err_long)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: collect a line, then emit it reversed or in order.
    task automatic model_accept(input logic [DW-1:0] data, input logic last, input logic user,
                                output logic sh, output logic lg);
        int n;
        exp_t e;
        if (line_q.size() == 0) begin
            line_w    = (cfg_line_width == 0 || int'(cfg_line_width) > int'(MAXW)) ? MAXW : int'(cfg_line_width);
            line_flip = cfg_hflip;
            line_sof  = user;
        end
        line_q.push_back(data);
        sh = 1'b0;
        lg = 1'b0;
        if (last || line_q.size() == int'(line_w)) begin
            sh = last && (line_q.size() < int'(line_w));
            lg = !last && (line_q.size() == int'(line_w));
            n  = line_q.size();
            for (int i = 0; i < n; i++) begin
                e.data = line_flip ? line_q[n-1-i] : line_q[i];
                e.last = (i == n - 1);
                e.user = (i == 0) && line_sof;
                sb.push_back(e);
            end
            line_q.delete();
        end
    endtask

    // Present one beat, wait for acceptance, then check the error pulses it causes.
    task automatic drive_beat(input logic [DW-1:0] data, input logic last, input logic user);
        logic sh, lg;
        int   waits;
        @(negedge clk);
        s_tdata  = data;
        s_tlast  = last;
        s_tuser  = user;
        s_tvalid = 1'b1;
        waits    = 0;
        #1;
        while (!s_tready) begin
            if (waits > 20000) begin
                check("s_tready_timeout", 64'(0), 64'(1));
                s_tvalid = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
            waits++;
            in_stalls++;
        end
        model_accept(data, last, user, sh, lg);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        check("err_short_line", 64'(err_short), 64'(sh));
        check("err_long_line", 64'(err_long), 64'(lg));
    endtask

    task automatic send_line(input int n, input logic with_last, input logic rnd,
                             input logic [DW-1:0] base, input logic sof, input logic gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
            drive_beat(rnd ? DW'($urandom) : base + DW'(i), with_last && (i == n - 1), sof && (i == 0));
        end
    endtask

    task automatic wait_drain(input string name);
        int c;
        c = 0;
        while (sb.size() != 0 && c < 20000) begin
            @(negedge clk);
            c++;
        end
        check(name, 64'(sb.size()), 64'(0));
        repeat (3) @(negedge clk);
    endtask

    // Output-side tready: always high or 50% random.
    always @(negedge clk) begin
        m_tready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end

    // Monitor: compare every output handshake against the scoreboard and check AXIS hold rules.
    logic          stall_prev = 1'b0;
    logic          mid_line   = 1'b0;
    logic [DW-1:0] held_data;
    logic          held_last;
    logic          held_user;
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (!rst_n) begin
            stall_prev = 1'b0;
            mid_line   = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_tvalid_held", 64'(m_tvalid), 64'(1));
                check("stall_tdata_held", 64'(m_tdata), 64'(held_data));
                check("stall_tlast_held", 64'(m_tlast), 64'(held_last));
                check("stall_tuser_held", 64'(m_tuser), 64'(held_user));
            end
            if (rdy_mode == 0 && mid_line) begin
                check("no_bubble_in_line", 64'(m_tvalid), 64'(1));
            end
            if (m_tvalid && m_tready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_beat", 64'(m_tdata), 64'(0) - 64'(1));
                end else begin
                    e = sb.pop_front();
                    check("out_tdata", 64'(m_tdata), 64'(e.data));
                    check("out_tlast", 64'(m_tlast), 64'(e.last));
                    check("out_tuser", 64'(m_tuser), 64'(e.user));
                    check("out_tstrb", 64'(m_tstrb), 64'({(DW/8){1'b1}}));
                end
                pops++;
                mid_line = !m_tlast;
            end
            stall_prev = m_tvalid && !m_tready;
            held_data  = m_tdata;
            held_last  = m_tlast;
            held_user  = m_tuser;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int st0;
        int p0;
        rst_n          = 1'b0;
        s_tvalid       = 1'b0;
        s_tdata        = '0;
        s_tlast        = 1'b0;
        s_tuser        = 1'b0;
        cfg_line_width = PW'(8);
        cfg_hflip      = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_tready", 64'(s_tready), 64'(0));
        check("rst_m_tvalid", 64'(m_tvalid), 64'(0));
        check("rst_m_tlast", 64'(m_tlast), 64'(0));
        check("rst_m_tuser", 64'(m_tuser), 64'(0));
        check("rst_m_tdata", 64'(m_tdata), 64'(0));
        check("rst_errs", 64'({err_short, err_long}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_s_tready", 64'(s_tready), 64'(1));

        // Flip W=8 with SOF, first-output latency
        rdy_mode = 0;
        send_line(8, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
        lat = 0;
        while (!m_tvalid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("first_tvalid_latency", 64'(lat), 64'(2));
        wait_drain("drain_flip8");

        // Two back-to-back lines, no input stall expected
        st0 = in_stalls;
        send_line(8, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
        send_line(8, 1'b1, 1'b0, 32'd8, 1'b0, 1'b0);
        check("b2b_no_input_stall", 64'(in_stalls - st0), 64'(0));
        wait_drain("drain_b2b");

        // Pass mode W=4; flip change mid-line only affects the next line
        cfg_line_width = PW'(4);
        cfg_hflip      = 1'b0;
        drive_beat(32'hA, 1'b0, 1'b1);
        drive_beat(32'hB, 1'b0, 1'b0);
        cfg_hflip = 1'b1;
        drive_beat(32'hC, 1'b0, 1'b0);
        drive_beat(32'hD, 1'b1, 1'b0);
        send_line(4, 1'b1, 1'b0, 32'h10, 1'b1, 1'b0);
        wait_drain("drain_mode");

        // Short line then a normal line
        cfg_line_width = PW'(8);
        send_line(5, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
        send_line(8, 1'b1, 1'b0, 32'h20, 1'b1, 1'b0);
        wait_drain("drain_short");

        // Long line: width reached without tlast, stray beats form the next line
        cfg_line_width = PW'(4);
        cfg_hflip      = 1'b0;
        send_line(6, 1'b1, 1'b0, 32'h30, 1'b1, 1'b0);
        wait_drain("drain_long");

        // Single-beat lines, with and without tlast
        cfg_line_width = PW'(1);
        cfg_hflip      = 1'b1;
        drive_beat(32'h55, 1'b1, 1'b1);
        drive_beat(32'h66, 1'b0, 1'b1);
        wait_drain("drain_len1");

        // Max-width lines with random output backpressure and input gaps; illegal widths clamp
        rdy_mode = 1;
        st0      = in_stalls;
        cfg_line_width = PW'(MAXW);
        cfg_hflip      = 1'($urandom_range(0, 1));
        send_line(int'(MAXW), 1'b1, 1'b1, 32'd0, 1'b1, 1'b1);
        cfg_line_width = PW'(0);
        cfg_hflip      = 1'($urandom_range(0, 1));
        send_line(int'(MAXW), 1'b1, 1'b1, 32'd0, 1'b1, 1'b1);
        cfg_line_width = PW'(1500);
        cfg_hflip      = 1'($urandom_range(0, 1));
        send_line(int'(MAXW), 1'b0, 1'b1, 32'd0, 1'($urandom_range(0, 1)), 1'b1);
        wait_drain("drain_random");
        check("backpressure_seen", 64'(in_stalls > st0), 64'(1));

        // Reset during output beat 3 of 8
        rdy_mode       = 0;
        cfg_line_width = PW'(8);
        cfg_hflip      = 1'b1;
        p0             = pops;
        send_line(8, 1'b1, 1'b0, 32'h40, 1'b1, 1'b0);
        lat = 0;
        while ((pops - p0) < 3 && lat < 100) begin
            @(negedge clk);
            #2;
            lat++;
        end
        check("reached_beat3", 64'((pops - p0) >= 3), 64'(1));
        rst_n = 1'b0;
        sb.delete();
        line_q.delete();
        @(posedge clk);
        #1;
        check("midrst_m_tvalid", 64'(m_tvalid), 64'(0));
        check("midrst_s_tready", 64'(s_tready), 64'(0));
        check("midrst_m_tdata", 64'(m_tdata), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("no_partial_after_rst", 64'(m_tvalid), 64'(0));
        end
        send_line(8, 1'b1, 1'b0, 32'h100, 1'b1, 1'b0);
        wait_drain("drain_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
